// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bus for pipelined_add_sub.
// The slave side belongs to the adder and the master side to its user.
interface pipelined_add_sub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage k resolves one WIDTH/STAGES-bit segment and registers its carry for stage k+1.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_add_sub_if.slave bus
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NGRP = SEG / 4;

    if (STAGES == 0 || (WIDTH % STAGES) != 0 || (SEG % 4) != 0) begin : g_param_err
        $error("pipelined_add_sub: WIDTH/STAGES must be a non-zero multiple of 4");
    end

    // One segment: 4-bit P/G groups, group carries formed in parallel from cin.
    // Returns {carry_out, sum}.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  s;
        logic [NGRP-1:0] gp;
        logic [NGRP-1:0] gg;
        logic [NGRP:0]   gc;
        logic [3:0]      bc;
        logic            term;
        p = a ^ b;
        g = a & b;
        for (int i = 0; i < NGRP; i++) begin
            gp[i] = &p[4*i +: 4];
            gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        end
        gc[0] = cin;
        for (int i = 0; i < NGRP; i++) begin
            gc[i+1] = cin;
            for (int j = 0; j <= i; j++) gc[i+1] = gc[i+1] & gp[j];
            for (int j = 0; j <= i; j++) begin
                term = gg[j];
                for (int k = j + 1; k <= i; k++) term = term & gp[k];
                gc[i+1] = gc[i+1] | term;
            end
        end
        s = '0;
        for (int i = 0; i < NGRP; i++) begin
            bc[0] = gc[i];
            bc[1] = g[4*i] | (p[4*i] & gc[i]);
            bc[2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
            bc[3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                  | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
            s[4*i +: 4] = p[4*i +: 4] ^ bc;
        end
        return {gc[NGRP], s};
    endfunction

    // rdy_w[s] is the readiness of the register fed by segment s.
    logic [STAGES:0] rdy_w;

    assign rdy_w[STAGES] = bus.out_ready;
    assign bus.in_ready  = rdy_w[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_seg
        localparam int unsigned Lo = s * SEG;
        localparam int unsigned Hi = Lo + SEG;

        logic [WIDTH-1:Lo] src_a;
        logic [WIDTH-1:Lo] src_b;
        logic              cin;
        logic              v_in;
        logic [SEG:0]      res;
        logic [Hi-1:0]     sum_d;
        logic [Hi-1:0]     sum_q;
        logic              c_q;
        logic              v_q;

        if (s == 0) begin : g_src
            // B is inverted here so later stages only ever add.
            assign src_a = bus.in_a;
            assign src_b = bus.in_b ^ {WIDTH{bus.in_sub}};
            assign cin   = bus.in_sub;
            assign v_in  = bus.in_valid;
            assign sum_d = res[SEG-1:0];
        end else begin : g_src
            assign src_a = g_seg[s-1].g_ops.a_q;
            assign src_b = g_seg[s-1].g_ops.b_q;
            assign cin   = g_seg[s-1].c_q;
            assign v_in  = g_seg[s-1].v_q;
            assign sum_d = {res[SEG-1:0], g_seg[s-1].sum_q};
        end

        assign res      = cla_seg(src_a[Hi-1:Lo], src_b[Hi-1:Lo], cin);
        assign rdy_w[s] = !v_q | rdy_w[s+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (rdy_w[s]) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= res[SEG];
                    sum_q <= sum_d;
                end
            end
        end

        if (s < STAGES - 1) begin : g_ops
            // Unprocessed upper operand bits ride along with their own beat.
            logic [WIDTH-1:Hi] a_q;
            logic [WIDTH-1:Hi] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (rdy_w[s] && v_in) begin
                    a_q <= src_a[WIDTH-1:Hi];
                    b_q <= src_b[WIDTH-1:Hi];
                end
            end
        end

        if (s == STAGES - 1) begin : g_out
            logic ovf_d;
            logic ovf_q;
            logic zero_d;
            logic zero_q;

            // Carry into the MSB is recovered from the MSB sum bit.
            assign ovf_d  = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ res[SEG-1] ^ res[SEG];
            assign zero_d = ~|sum_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (rdy_w[s] && v_in) begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end

            assign bus.out_valid = v_q;
            assign bus.out_sum   = sum_q;
            assign bus.out_carry = c_q;
            assign bus.out_ovf   = ovf_q;
            assign bus.out_zero  = zero_q;
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench: 32-bit/2-stage and 16-bit/4-stage instances of pipelined_add_sub.
module tb_pipelined_add_sub;

    logic clk = 1'b0;
    logic rst_n32 = 1'b1;
    logic rst_n16 = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(32)) bus32 ();
    pipelined_add_sub_if #(.WIDTH(16)) bus16 ();

    pipelined_add_sub #(.WIDTH(32), .STAGES(2)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n32),
        .bus   (bus32)
    );

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n16),
        .bus   (bus16)
    );

    logic [31:0] t3_a [8] = '{32'h12345678, 32'h00000005, 32'h7FFFFFFF, 32'h00000003,
                              32'h80000000, 32'h12345678, 32'h0000FFFF, 32'h7FFFFFFF};
    logic [31:0] t3_b [8] = '{32'h11111111, 32'h00000003, 32'h00000001, 32'h00000005,
                              32'h80000000, 32'h12345678, 32'h00000001, 32'hFFFFFFFF};
    logic        t3_s [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t3_r [8] = '{32'h23456789, 32'h00000002, 32'h80000000, 32'hFFFFFFFE,
                              32'h00000000, 32'h00000000, 32'h00010000, 32'h80000000};
    // {carry, ovf, zero}
    logic [2:0]  t3_f [8] = '{3'b000, 3'b100, 3'b010, 3'b000, 3'b111, 3'b101, 3'b000, 3'b010};

    logic [31:0] t4_a [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                              32'h44444444, 32'h55555555, 32'h66666666};
    logic [31:0] t4_r [6] = '{32'h11111112, 32'h22222223, 32'h33333334,
                              32'h44444445, 32'h55555556, 32'h66666667};
    logic        t4_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic sub);
        bus32.in_valid = v;
        bus32.in_a     = a;
        bus32.in_b     = b;
        bus32.in_sub   = sub;
    endtask

    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic sub);
        bus16.in_valid = v;
        bus16.in_a     = a;
        bus16.in_b     = b;
        bus16.in_sub   = sub;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int ret;
        logic acc;

        drive32(1'b0, '0, '0, 1'b0);
        drive16(1'b0, '0, '0, 1'b0);
        bus32.out_ready = 1'b0;
        bus16.out_ready = 1'b0;

        // Reset state
        #1;
        rst_n32 = 1'b0;
        rst_n16 = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, bus32.out_valid}, 32'd0);
        chk("rst_sum", bus32.out_sum, 32'd0);
        chk("rst_flags", {29'd0, bus32.out_carry, bus32.out_ovf, bus32.out_zero}, 32'd0);
        chk("rst_valid16", {31'd0, bus16.out_valid}, 32'd0);
        rst_n32 = 1'b1;
        rst_n16 = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, bus32.in_ready}, 32'd1);
        tick();

        // 1: 0xFFFFFFFF + 1 with two-edge latency
        drive32(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        #1;
        chk("t1_in_ready", {31'd0, bus32.in_ready}, 32'd1);
        tick();
        drive32(1'b0, '0, '0, 1'b0);
        chk("t1_early_valid", {31'd0, bus32.out_valid}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, bus32.out_valid}, 32'd1);
        chk("t1_sum", bus32.out_sum, 32'h00000000);
        chk("t1_flags", {29'd0, bus32.out_carry, bus32.out_ovf, bus32.out_zero}, 32'b101);
        bus32.out_ready = 1'b1;
        tick();

        // 2: subtraction edge cases, back to back
        drive32(1'b1, 32'h80000000, 32'h00000001, 1'b1);
        tick();
        drive32(1'b1, 32'h00000000, 32'h00000001, 1'b1);
        tick();
        chk("t2a_sum", bus32.out_sum, 32'h7FFFFFFF);
        chk("t2a_flags", {29'd0, bus32.out_carry, bus32.out_ovf, bus32.out_zero}, 32'b110);
        drive32(1'b0, '0, '0, 1'b0);
        tick();
        chk("t2b_sum", bus32.out_sum, 32'hFFFFFFFF);
        chk("t2b_flags", {29'd0, bus32.out_carry, bus32.out_ovf, bus32.out_zero}, 32'b000);
        tick();
        chk("t2_drained", {31'd0, bus32.out_valid}, 32'd0);

        // 3: eight beats streamed at full rate
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                drive32(1'b1, t3_a[i], t3_b[i], t3_s[i]);
                #1;
                chk("t3_in_ready", {31'd0, bus32.in_ready}, 32'd1);
            end else begin
                drive32(1'b0, '0, '0, 1'b0);
            end
            tick();
            if (i >= 1) begin
                chk("t3_valid", {31'd0, bus32.out_valid}, 32'd1);
                chk("t3_sum", bus32.out_sum, t3_r[i-1]);
                chk("t3_flags", {29'd0, bus32.out_carry, bus32.out_ovf, bus32.out_zero},
                    {29'd0, t3_f[i-1]});
            end
        end
        tick();
        chk("t3_drained", {31'd0, bus32.out_valid}, 32'd0);

        // 4: backpressure for four cycles while feeding
        idx = 0;
        ret = 0;
        for (int c = 0; c < 20 && ret < 6; c++) begin
            if (idx < 6) drive32(1'b1, t4_a[idx], 32'h00000001, 1'b0);
            else drive32(1'b0, '0, '0, 1'b0);
            bus32.out_ready = (c >= 4);
            #1;
            if (c < 5) chk("t4_in_ready", {31'd0, bus32.in_ready}, {31'd0, t4_rdy[c]});
            if (bus32.out_valid && !bus32.out_ready) chk("t4_hold", bus32.out_sum, t4_r[ret]);
            if (bus32.out_valid && bus32.out_ready) begin
                chk("t4_order", bus32.out_sum, t4_r[ret]);
                ret++;
            end
            acc = bus32.in_valid && bus32.in_ready;
            tick();
            if (acc) idx++;
        end
        chk("t4_count", ret, 32'd6);
        drive32(1'b0, '0, '0, 1'b0);
        #1;
        chk("t4_no_dup", {31'd0, bus32.out_valid}, 32'd0);
        tick();

        // 5: bubble collapse, then retire and accept in the same cycle
        bus32.out_ready = 1'b0;
        drive32(1'b1, 32'h0000000A, 32'h00000005, 1'b0);
        #1;
        chk("t5_rdy0", {31'd0, bus32.in_ready}, 32'd1);
        tick();
        drive32(1'b0, '0, '0, 1'b0);
        #1;
        chk("t5_rdy1", {31'd0, bus32.in_ready}, 32'd1);
        tick();
        drive32(1'b1, 32'h00000020, 32'h00000001, 1'b1);
        #1;
        chk("t5_rdy2", {31'd0, bus32.in_ready}, 32'd1);
        chk("t5_x_valid", {31'd0, bus32.out_valid}, 32'd1);
        tick();
        drive32(1'b0, '0, '0, 1'b0);
        #1;
        chk("t5_full", {31'd0, bus32.in_ready}, 32'd0);
        chk("t5_x_hold", bus32.out_sum, 32'h0000000F);
        tick();
        drive32(1'b1, 32'h00000100, 32'h00000200, 1'b0);
        bus32.out_ready = 1'b1;
        #1;
        chk("t5_simul_rdy", {31'd0, bus32.in_ready}, 32'd1);
        chk("t5_x_sum", bus32.out_sum, 32'h0000000F);
        tick();
        drive32(1'b0, '0, '0, 1'b0);
        chk("t5_y_sum", bus32.out_sum, 32'h0000001F);
        tick();
        chk("t5_z_valid", {31'd0, bus32.out_valid}, 32'd1);
        chk("t5_z_sum", bus32.out_sum, 32'h00000300);
        tick();
        chk("t5_drained", {31'd0, bus32.out_valid}, 32'd0);

        // 6: 16-bit, 4 stages; cross-segment carry then reset with beats in flight
        bus16.out_ready = 1'b1;
        drive16(1'b1, 16'h00FF, 16'h0001, 1'b0);
        #1;
        chk("t6_in_ready", {31'd0, bus16.in_ready}, 32'd1);
        tick();
        drive16(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("t6_latency", {31'd0, bus16.out_valid}, 32'd0);
            tick();
        end
        chk("t6_valid", {31'd0, bus16.out_valid}, 32'd1);
        chk("t6_sum", {16'd0, bus16.out_sum}, 32'h00000100);
        chk("t6_flags", {29'd0, bus16.out_carry, bus16.out_ovf, bus16.out_zero}, 32'b000);
        tick();
        bus16.out_ready = 1'b0;
        drive16(1'b1, 16'h1234, 16'h0001, 1'b0);
        tick();
        drive16(1'b1, 16'h2000, 16'h0002, 1'b0);
        tick();
        drive16(1'b1, 16'h3000, 16'h0001, 1'b1);
        tick();
        drive16(1'b0, '0, '0, 1'b0);
        tick();
        chk("t6_inflight_valid", {31'd0, bus16.out_valid}, 32'd1);
        chk("t6_inflight_sum", {16'd0, bus16.out_sum}, 32'h00001235);
        rst_n16 = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("t6_rst_sum", {16'd0, bus16.out_sum}, 32'd0);
        tick();
        tick();
        rst_n16 = 1'b1;
        bus16.out_ready = 1'b1;
        #1;
        chk("t6_post_rdy", {31'd0, bus16.in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t6_no_stale", {31'd0, bus16.out_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides. It is the clocked successor to the fixed 32-bit combinational adder, intended for ALU and address paths that need a registered result and flow control. The WIDTH-bit operation is split into STAGES equal segments. Each stage resolves one segment with 4-bit lookahead groups and registers the carry forward to the next stage.

Parameters:
WIDTH, 32, operand and result width in bits.
STAGES, 2, number of pipeline stages. Equals the latency in cycles. WIDTH/STAGES must be an integer multiple of 4.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sub  input  1  0 = A+B, 1 = A-B.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result this cycle.
out_sum  output  WIDTH  result.
out_carry  output  1  carry out of the MSB. For subtraction, 1 means no borrow.
out_ovf  output  1  two's-complement signed overflow.
out_zero  output  1  out_sum == 0.

Behaviour:
- Reset (rst_n low) is asynchronous.
  - Clears every stage valid bit.
  - Clears all data and carry registers.
  - out_valid, out_sum, out_carry, out_ovf and out_zero are 0 while reset is asserted and after reset.
  - in_ready is 1 once rst_n is high, because the pipeline is empty.
- Arithmetic:
  - Subtraction uses B inverted with carry-in 1. Addition uses carry-in 0.
  - Segment k (bits k*SEG .. k*SEG+SEG-1, where SEG = WIDTH/STAGES) is computed in stage k+1 using the registered carry from stage k.
  - Segment internals are 4-bit propagate/generate groups with group lookahead. There is no ripple across the whole word within a stage.
- Operand skew:
  - Stage k register holds the finished low segments (0..k-1), the raw high operand segments (already inverted for subtraction), and the inter-segment carry.
  - Upper operand bits travel with their beat. No beat sees another beat's bits.
- Flags:
  - out_carry is the final-segment carry out.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero is computed from the final sum and is registered with the result.
- Handshake:
  - A beat transfers when valid and ready are both high at a rising edge, on either side.
  - Stage readiness: ready[i] = !v[i] | ready[i+1], with ready[STAGES+1] = out_ready.
  - in_ready = ready[1]. This may be combinational from out_ready.
  - Bubbles collapse: an empty stage accepts even if downstream is stalled.
- Latency and throughput:
  - A beat accepted at edge E appears with out_valid = 1 after edge E+STAGES-1.
  - For STAGES = 1, the result is valid in the cycle after acceptance.
  - Full throughput is one beat per cycle when out_ready is held high.
- Stall: while out_valid & !out_ready, out_sum and all flags are held bit-stable. No beat is dropped or duplicated.
- Full pipeline: with all stages valid and out_ready = 0, in_ready = 0 and in_valid is ignored.
- Simultaneous events: when the output retires a beat in the same cycle as a beat is accepted with the pipeline full, every stage advances. in_ready is 1 in that cycle.
- Ordering: results leave in acceptance order.
- Reset mid-operation: all in-flight beats are discarded. No stale result appears after rst_n deasserts.
- Width and wrap: results wrap modulo 2^WIDTH, and the carry is reported on out_carry.
- Parameter checks: WIDTH or STAGES violating the divisibility rule is an elaboration error.

Test Plan:
1. WIDTH=32, STAGES=2. Add 0xFFFFFFFF + 0x00000001 -> out_sum 0x00000000, carry 1, zero 1, ovf 0. out_valid rises 2 edges after acceptance.
2. Subtract 0x80000000 - 0x00000001 -> 0x7FFFFFFF, carry 1, ovf 1, zero 0. Subtract 0x00000000 - 0x00000001 -> 0xFFFFFFFF, carry 0, ovf 0.
3. Stream 8 back-to-back random add/sub beats with out_ready = 1 -> 8 results in order on 8 consecutive cycles, each matching the reference model. in_ready stays 1 throughout.
4. Backpressure: drop out_ready for 4 cycles while feeding continuously -> in_ready falls once both stages are full. out_sum is stable during the stall. After release, every beat emerges exactly once, in order.
5. Bubble collapse: accept 1 beat, idle 1 cycle, accept 1 beat, with out_ready = 0 -> both stages fill and in_ready = 0 only then.
6. WIDTH=16, STAGES=4. Add 0x00FF + 0x0001 -> 0x0100, which checks the cross-segment carry. Then assert rst_n low with 3 beats in flight -> out_valid goes to 0 immediately and no result appears after reset is released.
